// File: rtl/score_recorder_pkg.sv
// Shared constants and state encoding for the score recorder.
package score_recorder_pkg;

    localparam int MAX_DURATION = 4;   // whole note, in beats
    localparam int LAST_NOTE    = 14;  // highest valid note number
    localparam int REST         = 0;   // rest / empty slot marker

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/score_recorder_score_ram.sv
// Score entry storage: one synchronous write port, one combinational read
// port, synchronous zeroing of every slot.
module score_ram #(
    parameter int NOTE_BITS = 4,
    parameter int BEAT_BITS = 5,
    parameter int SLOT_BITS = 4,
    parameter int MAX_NOTES = 16,
    localparam int ENTRY_W  = NOTE_BITS + 2 * BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 zero,
    input  logic                 we,
    input  logic [SLOT_BITS-1:0] waddr,
    input  logic [ENTRY_W-1:0]   wdata,
    input  logic [SLOT_BITS-1:0] rd_index,
    output logic [ENTRY_W-1:0]   rdata
);

    logic [ENTRY_W-1:0] mem_q [MAX_NOTES];
    logic [ENTRY_W-1:0] mem_d [MAX_NOTES];

    // Next contents: a single guarded write, out-of-range addresses ignored.
    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < MAX_NOTES))
            mem_d[waddr] = wdata;
    end

    // Storage flops with synchronous zeroing.
    always_ff @(posedge clk) begin
        if (zero) mem_q <= '{default: '0};
        else      mem_q <= mem_d;
    end

    // Zero-latency read; indices beyond the array read as empty.
    always_comb begin
        rdata = '0;
        if (32'(rd_index) < MAX_NOTES)
            rdata = mem_q[rd_index];
    end

endmodule

// File: rtl/score_recorder.sv
// Beat-synchronous note recorder: merges repeated beats into score entries
// and exposes committed plus live entries on a combinational read port.
module score_recorder
    import score_recorder_pkg::*;
#(
    parameter int NOTE_BITS      = 4,
    parameter int BEAT_BITS      = 5,
    parameter int SLOT_BITS      = 4,
    parameter int MAX_NOTES      = 16,
    parameter int BEATS_PER_PAGE = 16,
    parameter int MAX_DUR        = score_recorder_pkg::MAX_DURATION
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat_tick,
    input  logic [NOTE_BITS-1:0] note_in,
    input  logic                 clear,
    input  logic [SLOT_BITS-1:0] rd_index,
    output logic [NOTE_BITS-1:0] rd_note,
    output logic [BEAT_BITS-1:0] rd_start_beat,
    output logic [BEAT_BITS-1:0] rd_duration,
    output logic [SLOT_BITS:0]   note_count,
    output logic [BEAT_BITS-1:0] beat,
    output logic                 page_done,
    output logic                 overflow
);

    localparam int ENTRY_W = NOTE_BITS + 2 * BEAT_BITS;

    state_e                 state_q, state_d;
    logic [BEAT_BITS-1:0]   beat_q, beat_d;
    logic [SLOT_BITS:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [NOTE_BITS-1:0]   cur_note_q, cur_note_d;
    logic [BEAT_BITS-1:0]   cur_start_q, cur_start_d;
    logic [BEAT_BITS-1:0]   cur_dur_q, cur_dur_d;

    logic [NOTE_BITS-1:0]   n;
    logic                   commit;
    logic                   we;
    logic [ENTRY_W-1:0]     wentry;
    logic [ENTRY_W-1:0]     ram_rdata;
    logic [ENTRY_W-1:0]     rd_entry;

    // Out-of-range note numbers are rests.
    always_comb begin
        n = NOTE_BITS'(REST);
        if (32'(note_in) >= 1 && 32'(note_in) <= LAST_NOTE)
            n = note_in;
    end

    // Tick processing: merge/commit/start, beat advance, page-end flush.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        cur_note_d  = cur_note_q;
        cur_start_d = cur_start_q;
        cur_dur_d   = cur_dur_q;
        commit      = 1'b0;
        wentry      = {cur_note_q, cur_start_q, cur_dur_q};
        we          = 1'b0;
        if (beat_tick && state_q != ST_DONE) begin
            if (state_q == ST_HOLD && n == cur_note_q && cur_dur_q < BEAT_BITS'(MAX_DUR)) begin
                cur_dur_d = cur_dur_q + BEAT_BITS'(1);
            end else begin
                if (state_q == ST_HOLD) commit = 1'b1;
                if (n != NOTE_BITS'(REST)) begin
                    state_d     = ST_HOLD;
                    cur_note_d  = n;
                    cur_start_d = beat_q;
                    cur_dur_d   = BEAT_BITS'(1);
                end else begin
                    state_d     = ST_IDLE;
                    cur_note_d  = '0;
                    cur_start_d = '0;
                    cur_dur_d   = '0;
                end
            end
            beat_d = beat_q + BEAT_BITS'(1);
            // Last beat: flush whatever is held; only one commit fits, so a
            // note that would start here after a commit is not recorded.
            if (beat_q == BEAT_BITS'(BEATS_PER_PAGE - 1)) begin
                if (!commit && state_d == ST_HOLD) begin
                    commit = 1'b1;
                    wentry = {cur_note_d, cur_start_d, cur_dur_d};
                end
                state_d     = ST_DONE;
                cur_note_d  = '0;
                cur_start_d = '0;
                cur_dur_d   = '0;
            end
            if (commit) begin
                if (count_q == (SLOT_BITS+1)'(MAX_NOTES)) begin
                    overflow_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + (SLOT_BITS+1)'(1);
                end
            end
        end
    end

    // FSM and counters; clear behaves exactly like reset and beats a tick.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cur_note_q  <= '0;
            cur_start_q <= '0;
            cur_dur_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cur_note_q  <= cur_note_d;
            cur_start_q <= cur_start_d;
            cur_dur_q   <= cur_dur_d;
        end
    end

    score_ram #(
        .NOTE_BITS (NOTE_BITS),
        .BEAT_BITS (BEAT_BITS),
        .SLOT_BITS (SLOT_BITS),
        .MAX_NOTES (MAX_NOTES)
    ) u_ram (
        .clk      (clk),
        .zero     (reset || clear),
        .we       (we),
        .waddr    (count_q[SLOT_BITS-1:0]),
        .wdata    (wentry),
        .rd_index (rd_index),
        .rdata    (ram_rdata)
    );

    // Read mux: committed slot, else the growing live entry, else empty.
    always_comb begin
        rd_entry = '0;
        if ({1'b0, rd_index} < count_q)
            rd_entry = ram_rdata;
        else if ({1'b0, rd_index} == count_q && state_q == ST_HOLD)
            rd_entry = {cur_note_q, cur_start_q, cur_dur_q};
    end

    assign {rd_note, rd_start_beat, rd_duration} = rd_entry;
    assign note_count = count_q;
    assign beat       = beat_q;
    assign page_done  = (state_q == ST_DONE);
    assign overflow   = overflow_q;

endmodule
